// File: rtl/affine_to_jacob.sv
// ---------------------------------------------------------------------------
// affine_to_jacob
//   Converts an affine point (x,y) to Jacobian (X,Y,Z) over GF(p) for a
//   caller-supplied Z: X = x*Z^2 mod p, Y = y*Z^3 mod p, Z passed through.
//   One bit-serial, MSB-first interleaved modular multiplier is reused for
//   four products (t=z*z, X=x*t, t=t*z, Y=y*t), WIDTH clocks each.
//
//   Optional feature macro: AFFINE_Z_ONE_EN
//     When defined, a start with z==1 bypasses the multiplier and goes straight
//     to DONE (x3=x, y3=y, z3=1, done one clock after start, busy stays low).
//
// Ports
//   clk   : clock, rising edge
//   nrst  : asynchronous active-low reset
//   p     : odd prime modulus, held stable while busy
//   x,y   : affine coordinates (< p), sampled at start
//   z     : Jacobian Z (0 < z < p), sampled at start
//   flag  : start request, honoured only in IDLE
//   x3,y3,z3 : Jacobian result, valid from the done cycle, held until next done
//   busy  : high while the multiplier sequence runs
//   done  : one-cycle completion pulse
// ---------------------------------------------------------------------------
module affine_to_jacob #(
  parameter int WIDTH = 256
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  input  logic             flag,
  output logic [WIDTH-1:0] x3,
  output logic [WIDTH-1:0] y3,
  output logic [WIDTH-1:0] z3,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t           state_reg, state_next;
  logic [1:0]       op_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] p_reg, x_reg, y_reg, z_reg;
  logic [WIDTH-1:0] t_reg;      // z^2, then z^3
  logic [WIDTH-1:0] xres_reg;   // X before it is published
  logic [WIDTH-1:0] yres_reg;   // Y before it is published
  logic [WIDTH-1:0] x3_reg, y3_reg, z3_reg;
  logic             busy_reg, done_reg;

  // Multiplier operand selection per op
  logic [WIDTH-1:0] mul_a, mul_b;
  logic             b_bit;
  logic [WIDTH:0]   dbl, dbl_red, add, add_red;
  logic [WIDTH-1:0] acc_step;

  always_comb begin
    mul_a = z_reg;
    mul_b = z_reg;
    case (op_reg)
      2'd0: begin mul_a = z_reg; mul_b = z_reg; end
      2'd1: begin mul_a = x_reg; mul_b = t_reg; end
      2'd2: begin mul_a = t_reg; mul_b = z_reg; end
      default: begin mul_a = y_reg; mul_b = t_reg; end
    endcase
  end

  // One interleaved step: acc = 2*acc mod p, then conditionally + a mod p.
  // Each partial sum is below 2p, so one WIDTH+1-bit subtract suffices.
  always_comb begin
    b_bit   = mul_b[cnt_reg];
    dbl     = {acc_reg, 1'b0};
    dbl_red = (dbl >= {1'b0, p_reg}) ? (dbl - {1'b0, p_reg}) : dbl;
    add     = {1'b0, dbl_red[WIDTH-1:0]} + {1'b0, mul_a};
    add_red = (add >= {1'b0, p_reg}) ? (add - {1'b0, p_reg}) : add;
    acc_step = b_bit ? add_red[WIDTH-1:0] : dbl_red[WIDTH-1:0];
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (flag) begin
`ifdef AFFINE_Z_ONE_EN
          if (z == WIDTH'(1)) state_next = DONE;
          else                state_next = MUL;
`else
          state_next = MUL;
`endif
        end
      end
      MUL:     if (op_reg == 2'd3 && cnt_reg == '0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= IDLE;
      op_reg    <= '0;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      p_reg     <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      t_reg     <= '0;
      xres_reg  <= '0;
      yres_reg  <= '0;
      x3_reg    <= '0;
      y3_reg    <= '0;
      z3_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next == MUL);
      done_reg  <= (state_reg == DONE);
      case (state_reg)
        IDLE: begin
          if (flag) begin
            p_reg   <= p;
            x_reg   <= x;
            y_reg   <= y;
            z_reg   <= z;
            op_reg  <= '0;
            cnt_reg <= CW'(WIDTH - 1);
            acc_reg <= '0;
`ifdef AFFINE_Z_ONE_EN
            // Bypass path publishes the inputs unchanged
            xres_reg <= x;
            yres_reg <= y;
`endif
          end
        end
        MUL: begin
          if (cnt_reg == '0) begin
            case (op_reg)
              2'd0:    t_reg    <= acc_step;
              2'd1:    xres_reg <= acc_step;
              2'd2:    t_reg    <= acc_step;
              default: yres_reg <= acc_step;
            endcase
            acc_reg <= '0;
            op_reg  <= op_reg + 2'd1;
            cnt_reg <= CW'(WIDTH - 1);
          end else begin
            acc_reg <= acc_step;
            cnt_reg <= cnt_reg - CW'(1);
          end
        end
        DONE: begin
          x3_reg <= xres_reg;
          y3_reg <= yres_reg;
          z3_reg <= z_reg;
        end
        default: ;
      endcase
    end
  end

  assign x3   = x3_reg;
  assign y3   = y3_reg;
  assign z3   = z3_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_affine_to_jacob.sv
// Testbench for affine_to_jacob: WIDTH=8 and WIDTH=256 instances.
// Stimulus pushes expected results into queues; monitors pop on done.
module tb_affine_to_jacob;

  typedef struct {
    logic [255:0] ex;
    logic [255:0] ey;
    logic [255:0] ez;
    int           issue;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests  = 0;
  int failed = 0;

  exp_t q8[$];
  exp_t qb[$];

  // small instance
  logic [7:0] p8 = '0, x8 = '0, y8 = '0, z8 = '0;
  logic [7:0] x3_8, y3_8, z3_8;
  logic       flag8 = 1'b0, busy8, done8;

  affine_to_jacob #(.WIDTH(8)) u_small (
    .clk(clk), .nrst(nrst), .p(p8), .x(x8), .y(y8), .z(z8), .flag(flag8),
    .x3(x3_8), .y3(y3_8), .z3(z3_8), .busy(busy8), .done(done8)
  );

  // large instance
  logic [255:0] pb = '0, xb = '0, yb = '0, zb = '0;
  logic [255:0] x3_b, y3_b, z3_b;
  logic         flagb = 1'b0, busyb, doneb;

  affine_to_jacob #(.WIDTH(256)) u_big (
    .clk(clk), .nrst(nrst), .p(pb), .x(xb), .y(yb), .z(zb), .flag(flagb),
    .x3(x3_b), .y3(y3_b), .z3(z3_b), .busy(busyb), .done(doneb)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  int busy_cnt8 = 0;
  int busy_cntb = 0;
  always @(negedge clk) begin
    if (busy8) busy_cnt8++;
    if (busyb) busy_cntb++;
  end

  // Monitor: small instance
  always @(negedge clk) begin
    if (nrst && done8 === 1'b1) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("x3_8", {248'd0, x3_8}, e.ex);
        chk("y3_8", {248'd0, y3_8}, e.ey);
        chk("z3_8", {248'd0, z3_8}, e.ez);
        chk("latency8", 256'(cyc - e.issue), 256'(e.lat));
        $display("[TB] done8 x3=%0d y3=%0d z3=%0d lat=%0d", x3_8, y3_8, z3_8, cyc - e.issue);
      end
    end
  end

  // Monitor: large instance
  always @(negedge clk) begin
    if (nrst && doneb === 1'b1) begin
      if (qb.size() == 0) begin
        chk("unexpected_done256", 1, 0);
      end else begin
        exp_t e;
        e = qb.pop_front();
        chk("x3_256", x3_b, e.ex);
        chk("y3_256", y3_b, e.ey);
        chk("z3_256", z3_b, e.ez);
        chk("latency256", 256'(cyc - e.issue), 256'(e.lat));
        $display("[TB] done256 lat=%0d", cyc - e.issue);
      end
    end
  end

  // Issue one small conversion; optional extra flag pulse at cycle extra_at
  task automatic run8(input logic [7:0] pp, xx, yy, zz, ex, ey, ez,
                      input int lat, input int bcnt, input int extra_at);
    exp_t e;
    int t;
    @(negedge clk);
    p8 = pp; x8 = xx; y8 = yy; z8 = zz; flag8 = 1'b1;
    busy_cnt8 = 0;
    e.ex = {248'd0, ex}; e.ey = {248'd0, ey}; e.ez = {248'd0, ez};
    e.issue = cyc + 1; e.lat = lat;
    q8.push_back(e);
    @(negedge clk);
    flag8 = 1'b0;
    t = 0;
    while (q8.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
      flag8 = (extra_at != 0 && t == extra_at) ? 1'b1 : 1'b0;
    end
    flag8 = 1'b0;
    if (t >= 2000) begin
      chk("timeout8", 1, 0);
      q8.delete();
    end
    chk("busy_cycles8", 256'(busy_cnt8), 256'(bcnt));
  endtask

  localparam logic [255:0] P256 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
  localparam logic [255:0] GX   = 256'h79BE667EF9DCBBAC55A06295CE870B07029BFCDB2DCE28D959F2815B16F81798;
  localparam logic [255:0] GY   = 256'h483ADA7726A3C4655DA4FBFC0E1108A8FD17B448A68554199C47D08FFB10D4B8;

  initial begin
    int zlat, zbusy, t;
    logic [511:0] wide;
    exp_t e;

`ifdef AFFINE_Z_ONE_EN
    zlat = 1; zbusy = 0;
`else
    zlat = 33; zbusy = 32;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_x3", {248'd0, x3_8}, 0);
    chk("rst_y3", {248'd0, y3_8}, 0);
    chk("rst_z3", {248'd0, z3_8}, 0);
    chk("rst_done", {255'd0, done8}, 0);
    chk("rst_busy", {255'd0, busy8}, 0);
    chk("rst_done256", {255'd0, doneb}, 0);
    nrst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic vector
    run8(8'd251, 8'd3, 8'd5, 8'd2, 8'd12, 8'd40, 8'd2, 33, 32, 0);
    // z = -1 wrap
    run8(8'd251, 8'd250, 8'd250, 8'd250, 8'd250, 8'd1, 8'd250, 33, 32, 0);
    // z = 1
    run8(8'd251, 8'd7, 8'd9, 8'd1, 8'd7, 8'd9, 8'd1, zlat, zbusy, 0);
    // Extra vector: x=10,y=20,z=3 -> t=9, X=90, t=27, Y=540 mod 251=38
    run8(8'd251, 8'd10, 8'd20, 8'd3, 8'd90, 8'd38, 8'd3, 33, 32, 0);
    // Second flag 10 clocks in is ignored
    run8(8'd251, 8'd3, 8'd5, 8'd2, 8'd12, 8'd40, 8'd2, 33, 32, 10);
    repeat (40) @(negedge clk);   // any stray done hits the monitor

    // Reset mid-operation
    @(negedge clk);
    p8 = 8'd251; x8 = 8'd4; y8 = 8'd6; z8 = 8'd5; flag8 = 1'b1;
    @(negedge clk);
    flag8 = 1'b0;
    repeat (19) @(negedge clk);
    nrst = 1'b0;
    #1;
    chk("abort_x3", {248'd0, x3_8}, 0);
    chk("abort_y3", {248'd0, y3_8}, 0);
    chk("abort_z3", {248'd0, z3_8}, 0);
    chk("abort_busy", {255'd0, busy8}, 0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done_z3", {248'd0, z3_8}, 0);
    // New op after abort: x=4,y=6,z=5 -> t=25, X=100, t=125, Y=750 mod 251=248
    run8(8'd251, 8'd4, 8'd6, 8'd5, 8'd100, 8'd248, 8'd5, 33, 32, 0);

    // 256-bit secp256k1 vector
    @(negedge clk);
    pb = P256; xb = GX; yb = GY; zb = 256'd2; flagb = 1'b1;
    busy_cntb = 0;
    wide = ({256'd0, GX} * 512'd4) % {256'd0, P256};
    e.ex = wide[255:0];
    wide = ({256'd0, GY} * 512'd8) % {256'd0, P256};
    e.ey = wide[255:0];
    e.ez = 256'd2;
    e.issue = cyc + 1;
    e.lat = 4 * 256 + 1;
    qb.push_back(e);
    @(negedge clk);
    flagb = 1'b0;
    t = 0;
    while (qb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("timeout256", 1, 0);
    chk("busy_cycles256", 256'(busy_cntb), 256'(1024));

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
